// File: rtl/mcdt_pkg.sv
// Shared constants and types for the three-channel data concentrator.
// Imported by the channel FIFO and the top level.
package mcdt_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int MARGIN_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int N_CHNL     = 3;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [MARGIN_W-1:0] margin_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2
  } chnl_id_t;

  typedef struct packed {
    logic     val;
    chnl_id_t id;
    data_t    data;
  } beat_t;

  function automatic margin_t free_of(
    input margin_t count
  );
    return margin_t'(FIFO_DEPTH) - count;
  endfunction

endpackage

// File: rtl/mcdt_chnl_fifo.sv
// Per-channel synchronous FIFO with valid/ready write side,
// combinational read head and a registered-count free-space output.
module mcdt_chnl_fifo
  import mcdt_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  data_t   wdata,
  input  logic    pop,
  output data_t   rdata,
  output logic    empty,
  output logic    ready,
  output margin_t margin
);

  data_t   mem [FIFO_DEPTH];
  ptr_t    wr_ptr;
  ptr_t    rd_ptr;
  margin_t count;
  logic    do_push;
  logic    do_pop;

  assign ready   = count < margin_t'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign margin  = free_of(count);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally: depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/multi_chnl_data_trans.sv
// Three-channel concentrator: per-channel FIFOs drained by a
// strict-priority arbiter (ch0 > ch1 > ch2) onto one output bus.
module multi_chnl_data_trans
  import mcdt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] ch0_data_i,
  input  logic        ch0_valid_i,
  output logic        ch0_ready_o,
  output logic [5:0]  ch0_margin_o,
  input  logic [31:0] ch1_data_i,
  input  logic        ch1_valid_i,
  output logic        ch1_ready_o,
  output logic [5:0]  ch1_margin_o,
  input  logic [31:0] ch2_data_i,
  input  logic        ch2_valid_i,
  output logic        ch2_ready_o,
  output logic [5:0]  ch2_margin_o,
  output logic [31:0] mcdt_data_o,
  output logic        mcdt_val_o,
  output logic [1:0]  mcdt_id_o
);

  data_t   din   [N_CHNL];
  logic    vin   [N_CHNL];
  data_t   head  [N_CHNL];
  logic    empty [N_CHNL];
  logic    rdy   [N_CHNL];
  margin_t mrg   [N_CHNL];
  logic    pop   [N_CHNL];

  beat_t sel;
  beat_t out_q;

  assign din[0] = ch0_data_i;
  assign din[1] = ch1_data_i;
  assign din[2] = ch2_data_i;
  assign vin[0] = ch0_valid_i;
  assign vin[1] = ch1_valid_i;
  assign vin[2] = ch2_valid_i;

  assign ch0_ready_o  = rdy[0];
  assign ch1_ready_o  = rdy[1];
  assign ch2_ready_o  = rdy[2];
  assign ch0_margin_o = mrg[0];
  assign ch1_margin_o = mrg[1];
  assign ch2_margin_o = mrg[2];

  for (genvar g = 0; g < N_CHNL; g++) begin : g_fifo
    mcdt_chnl_fifo u_fifo (
      .clk    (clk_i),
      .rst_n  (rstn_i),
      .push   (vin[g]),
      .wdata  (din[g]),
      .pop    (pop[g]),
      .rdata  (head[g]),
      .empty  (empty[g]),
      .ready  (rdy[g]),
      .margin (mrg[g])
    );
  end

  // Terms are made mutually exclusive to encode the fixed priority.
  always_comb begin
    pop[0]   = 1'b0;
    pop[1]   = 1'b0;
    pop[2]   = 1'b0;
    sel.val  = 1'b0;
    sel.id   = out_q.id;
    sel.data = '0;
    unique case (1'b1)
      !empty[0]: begin
        pop[0]   = 1'b1;
        sel.val  = 1'b1;
        sel.id   = CH0;
        sel.data = head[0];
      end
      empty[0] && !empty[1]: begin
        pop[1]   = 1'b1;
        sel.val  = 1'b1;
        sel.id   = CH1;
        sel.data = head[1];
      end
      empty[0] && empty[1] && !empty[2]: begin
        pop[2]   = 1'b1;
        sel.val  = 1'b1;
        sel.id   = CH2;
        sel.data = head[2];
      end
      default: ;
    endcase
  end

  // Idle cycles clear data and valid but keep the last id.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      out_q.val  <= 1'b0;
      out_q.id   <= CH0;
      out_q.data <= '0;
    end else begin
      out_q <= sel;
    end
  end

  assign mcdt_val_o  = out_q.val;
  assign mcdt_id_o   = out_q.id;
  assign mcdt_data_o = out_q.data;

endmodule

// File: tb/tb_multi_chnl_data_trans.sv
// Directed self-checking bench for the three-channel concentrator.
// Inputs and checks both happen 1 time unit after each rising edge.
module tb_multi_chnl_data_trans;

  logic        clk;
  logic        rstn;
  logic [31:0] d0, d1, d2;
  logic        v0, v1, v2;
  logic        r0, r1, r2;
  logic [5:0]  m0, m1, m2;
  logic [31:0] odata;
  logic        oval;
  logic [1:0]  oid;

  int n_chk;
  int n_err;

  multi_chnl_data_trans dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .ch0_data_i   (d0),
    .ch0_valid_i  (v0),
    .ch0_ready_o  (r0),
    .ch0_margin_o (m0),
    .ch1_data_i   (d1),
    .ch1_valid_i  (v1),
    .ch1_ready_o  (r1),
    .ch1_margin_o (m1),
    .ch2_data_i   (d2),
    .ch2_valid_i  (v2),
    .ch2_ready_o  (r2),
    .ch2_margin_o (m2),
    .mcdt_data_o  (odata),
    .mcdt_val_o   (oval),
    .mcdt_id_o    (oid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    v0 = 0; v1 = 0; v2 = 0;
    d0 = '0; d1 = '0; d2 = '0;
  endtask

  task automatic set_ch(
    input int          ch,
    input logic [31:0] w
  );
    case (ch)
      0: begin v0 = 1; d0 = w; end
      1: begin v1 = 1; d1 = w; end
      default: begin v2 = 1; d2 = w; end
    endcase
  endtask

  function automatic logic [5:0] mrg_of(input int ch);
    case (ch)
      0: return m0;
      1: return m1;
      default: return m2;
    endcase
  endfunction

  task automatic expect_beat(
    input string       tag,
    input logic [31:0] w,
    input logic [1:0]  id
  );
    chk({tag, "_val"}, oval, 1);
    chk({tag, "_data"}, odata, w);
    chk({tag, "_id"}, oid, id);
  endtask

  initial begin
    logic [31:0] w;
    logic        acc_rdy;
    int          n_acc;

    n_chk = 0;
    n_err = 0;
    idle_in();
    rstn = 0;

    // reset state
    repeat (10) step();
    chk("rst_r0", r0, 1);
    chk("rst_r1", r1, 1);
    chk("rst_r2", r2, 1);
    chk("rst_m0", m0, 32);
    chk("rst_m1", m1, 32);
    chk("rst_m2", m2, 32);
    chk("rst_val", oval, 0);
    chk("rst_data", odata, 0);
    chk("rst_id", oid, 0);
    rstn = 1;
    step();
    chk("idle_val", oval, 0);

    // one word at a time per channel, fixed 2-clock latency
    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 10; k++) begin
        w = 32'h00C0_0000 + (32'(ch) << 16) + 32'(k);
        set_ch(ch, w);
        step();
        idle_in();
        chk("seq_pre_val", oval, 0);
        chk("seq_m_push", mrg_of(ch), 31);
        step();
        expect_beat("seq", w, 2'(ch));
        chk("seq_m_pop", mrg_of(ch), 32);
      end
    end
    step();
    chk("seq_end_val", oval, 0);
    chk("seq_end_data", odata, 0);
    chk("seq_end_id", oid, 2);

    // same-cycle writes resolve by priority
    set_ch(0, 32'hA0);
    set_ch(1, 32'hA1);
    set_ch(2, 32'hA2);
    step();
    idle_in();
    step();
    expect_beat("pri0", 32'hA0, 0);
    step();
    expect_beat("pri1", 32'hA1, 1);
    step();
    expect_beat("pri2", 32'hA2, 2);
    step();
    chk("pri_end_val", oval, 0);
    chk("pri_end_id", oid, 2);

    // ch0 streams and starves ch2 until ch2 fills
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      set_ch(0, 32'h100 + 32'(i));
      acc_rdy = r2;
      chk("full_rdy_model", acc_rdy, (n_acc < 32) ? 1 : 0);
      set_ch(2, 32'h200 + 32'(i));
      step();
      if (acc_rdy) n_acc++;
      chk("full_m2", m2, 6'(32 - n_acc));
      if (i == 0) begin
        chk("full_val0", oval, 0);
      end else begin
        expect_beat("full_ch0", 32'h100 + 32'(i - 1), 0);
      end
    end
    chk("full_acc", n_acc, 32);
    chk("full_m2_zero", m2, 0);
    chk("full_r2_low", r2, 0);
    chk("full_m0", m0, 31);
    idle_in();
    step();
    expect_beat("full_last0", 32'h100 + 32'd39, 0);
    for (int k = 0; k < 32; k++) begin
      step();
      expect_beat("drain2", 32'h200 + 32'(k), 2);
    end
    chk("drain_m2", m2, 32);
    chk("drain_r2", r2, 1);
    step();
    chk("drain_end_val", oval, 0);

    // push and pop in the same cycle on ch1
    for (int i = 0; i < 20; i++) begin
      set_ch(1, 32'h300 + 32'(i));
      step();
      chk("pp_m1", m1, 31);
      if (i == 0) chk("pp_val0", oval, 0);
      else expect_beat("pp", 32'h300 + 32'(i - 1), 1);
    end
    idle_in();
    step();
    expect_beat("pp_last", 32'h300 + 32'd19, 1);
    chk("pp_m1_end", m1, 32);
    step();

    // reset while ch1 still holds words
    for (int i = 0; i < 8; i++) begin
      set_ch(0, 32'h400 + 32'(i));
      if (i < 5) set_ch(1, 32'h500 + 32'(i));
      else begin v1 = 0; d1 = '0; end
      step();
    end
    chk("mr_m1_pre", m1, 27);
    chk("mr_val_pre", oval, 1);
    chk("mr_id_pre", oid, 0);
    idle_in();
    rstn = 0;
    step();
    rstn = 1;
    chk("mr_m1", m1, 32);
    chk("mr_m0", m0, 32);
    chk("mr_val", oval, 0);
    chk("mr_data", odata, 0);
    chk("mr_id", oid, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mr_no_beat", oval, 0);
    end
    chk("mr_m1_end", m1, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multi_chnl_data_trans.md
Name: multi_chnl_data_trans

Overview:
- Three-channel data concentrator (the "mcdt" block). Each input channel has a 32-word slave FIFO with a valid/ready write interface and a free-space (margin) indicator.
- A fixed-priority arbiter drains the FIFOs onto one shared output bus, one word per cycle, tagged with the source channel id.
- Sits between three independent data producers and a single downstream consumer that is always ready.

Parameters:
- DATA_W, 32, width of channel and output data.
- FIFO_DEPTH, 32, words per channel FIFO. Margin width is $clog2(FIFO_DEPTH)+1, which is 6.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- chN_data_i  in  32  channel N write data, for N = 0, 1, 2.
- chN_valid_i  in  1  channel N write request.
- chN_ready_o  out  1  channel N FIFO not full.
- chN_margin_o  out  6  channel N free entries (FIFO_DEPTH minus count).
- mcdt_data_o  out  32  output word.
- mcdt_val_o  out  1  output word valid.
- mcdt_id_o  out  2  source channel of the output word (0, 1 or 2).

Behaviour:
- Reset: on a rising edge with rstn_i = 0:
  - all FIFOs are emptied;
  - chN_ready_o = 1, chN_margin_o = 32;
  - mcdt_val_o = 0, mcdt_data_o = 0, mcdt_id_o = 0.
  - Reset asserted mid-operation discards all buffered words at that edge; nothing is flushed to the output.
- Write handshake: a word is pushed at an edge where chN_valid_i && chN_ready_o.
  - If valid is high while ready is low, the write is dropped; the producer must hold the word.
  - Data is sampled only when valid is high.
- chN_ready_o = (count < FIFO_DEPTH). chN_margin_o = FIFO_DEPTH − count. Both are registered-count derived and update the cycle after the push/pop edge.
- Same-cycle push and pop on one FIFO leaves the count unchanged. A push into a full FIFO cannot occur because ready is low.
- FIFO ordering is first in, first out. Pointers wrap modulo FIFO_DEPTH.
- Arbiter:
  - Each cycle it selects the lowest-numbered non-empty FIFO (strict priority ch0 > ch1 > ch2) and pops one word.
  - At that edge it registers mcdt_data_o = word, mcdt_id_o = channel, mcdt_val_o = 1.
  - If all FIFOs are empty, it registers mcdt_val_o = 0, mcdt_data_o = 0 and holds mcdt_id_o at its previous value.
  - No backpressure from the output.
- Latency: a word pushed at edge E into an empty system pops and is registered at edge E+1. mcdt_val_o is high in the cycle after E+1, i.e. 2 clocks after valid is presented.
- Starvation: lower channels may starve while a higher channel has data. This is intentional.
- Throughput: 1 word per clock aggregate.

Decomposition:
- Package mcdt_pkg:
  - DATA_W, FIFO_DEPTH, MARGIN_W constants;
  - typedef chnl_id_t (2-bit) with CH0/CH1/CH2 values;
  - typedef data_t.
- One sub-module, mcdt_chnl_fifo (sync FIFO with push/pop, data out, empty, ready, margin), instantiated three times.
- Arbiter and output register live in the top module.

Test Plan:
- Reset: hold rstn_i low 10 clocks. Required: all chN_ready_o = 1, chN_margin_o = 32, mcdt_val_o = 0, mcdt_data_o = 0.
- Single-channel sequence: ch0 writes 0x00C0_0000..0x00C0_0009, each as a one-cycle valid pulse followed by one idle cycle. Then ch1 writes 0x00C1_0000..0x00C1_0009, then ch2 writes 0x00C2_0000..0x00C2_0009. Required:
  - 30 output beats in the same order;
  - each beat appears 2 clocks after its valid cycle;
  - ids 0, 1, 2 respectively;
  - margin never below 31.
- Priority: in one cycle, write 0xA0 on ch0, 0xA1 on ch1, 0xA2 on ch2. Required: three consecutive beats (0xA0, id 0), (0xA1, id 1), (0xA2, id 2), then val = 0.
- Full/backpressure: ch0 valid continuously with incrementing data while ch2 also writes continuously for 40 cycles. Required:
  - ch2 fills;
  - ch2_margin_o reaches 0 and ch2_ready_o = 0 after 32 accepts;
  - further ch2 data is not accepted;
  - no ch2 output beats while ch0 has data;
  - once ch0 stops, the 32 ch2 words drain in order and margin returns to 32.
- Simultaneous push/pop: keep ch1 valid every cycle with ch0/ch2 idle. Required: ch1_margin_o steady at 31, continuous val = 1 beats with id 1.
- Mid-operation reset: load 5 words into ch1, pull rstn_i low for 1 clock before they drain. Required: next cycle ch1_margin_o = 32, mcdt_val_o = 0, and no remaining ch1 words are ever output.
